// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus initiator: issues load/store requests, stalls the pipeline, returns aligned load data.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses skip the bus and report out_misalign.
module mem_dbus_ctrl #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_is_load,
    input  logic          in_is_store,
    input  logic [1:0]    in_size,
    input  logic          in_unsigned,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    output logic          dreq_valid,
    output logic [AW-1:0] dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [DW-1:0] dreq_data,
    input  logic          dresp_data_ok,
    input  logic [DW-1:0] dresp_data,
    output logic          Dwait,
    output logic          out_done,
    output logic [DW-1:0] out_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic          out_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [7:0]    strobe_q, strobe_d;
    logic [DW-1:0] data_q, data_d;
    logic          is_load_q, is_load_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          memop;
    logic [7:0]    mask;
    logic [DW-1:0] shifted;
    logic [DW-1:0] ext;
`ifdef MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
    logic          misaligned;
`endif

    assign memop = in_valid & (in_is_load | in_is_store);

    always_comb begin
        mask = 8'h01;
        case (in_size)
            2'd0: mask = 8'h01;
            2'd1: mask = 8'h03;
            2'd2: mask = 8'h0F;
            2'd3: mask = 8'hFF;
            default: mask = 8'h01;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = in_addr[0];
            2'd2: misaligned = |in_addr[1:0];
            2'd3: misaligned = |in_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end
`endif

    // Load data is aligned using the address captured at issue, not the live pipeline input.
    always_comb begin
        shifted = dresp_data >> {addr_q[2:0], 3'b000};
        ext     = shifted;
        case (size_q)
            2'd0: ext = {{(DW-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'd1: ext = {{(DW-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            2'd2: ext = {{(DW-32){~unsigned_q & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        strobe_d   = strobe_q;
        data_d     = data_q;
        is_load_d  = is_load_q;
        rdata_d    = rdata_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memop) begin
                    addr_d     = in_addr;
                    size_d     = in_size;
                    unsigned_d = in_unsigned;
                    strobe_d   = in_is_store ? (mask << in_addr[2:0]) : '0;
                    data_d     = in_wdata << {in_addr[2:0], 3'b000};
                    is_load_d  = in_is_load;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (dresp_data_ok) begin
                    rdata_d = is_load_q ? ext : '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            strobe_q   <= '0;
            data_q     <= '0;
            is_load_q  <= 1'b0;
            rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            is_load_q  <= is_load_d;
            rdata_q    <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign dreq_valid  = (state_q == REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = {1'b0, size_q};
    assign dreq_strobe = strobe_q;
    assign dreq_data   = data_q;
    assign Dwait       = ((state_q == IDLE) & memop) | (state_q == REQ);
    assign out_done    = (state_q == DONE);
    assign out_rdata   = rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign out_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: table-driven transactions plus reset, flush and misalign sequences.
// Completed loads are checked against a scoreboard queue of expected results.
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_unsigned;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        Dwait, out_done;
    logic [63:0] out_rdata;
`ifdef MISALIGN_TRAP_EN
    logic        out_misalign;
`endif

    always #5 clk = ~clk;

    mem_dbus_ctrl #(.AW(64), .DW(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .Dwait(Dwait), .out_done(out_done), .out_rdata(out_rdata)
`ifdef MISALIGN_TRAP_EN
        , .out_misalign(out_misalign)
`endif
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] resp;
        int unsigned lat;
        logic [7:0]  strb;
        logic [63:0] bdata;
        logic [63:0] rdata;
    } vec_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vecs[10];
    vec_t        extra;
    int          total = 0;
    int          bad = 0;
    logic [63:0] last_rdata = '0;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (out_done === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got out_done=1 want no completion");
            end else begin
                mon_e = sbq.pop_front();
                chk64("sb_rdata", out_rdata, mon_e.rdata);
`ifdef MISALIGN_TRAP_EN
                chk1("sb_misalign", out_misalign, mon_e.mis);
`endif
            end
        end
    end

    task automatic drive_idle();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0;
        dresp_data_ok = 1'b0; dresp_data = '0;
    endtask

    task automatic do_op(input vec_t v, input bit flush);
        @(negedge clk);
        in_valid = 1'b1; in_is_load = v.ld; in_is_store = v.st; in_size = v.sz;
        in_unsigned = v.uns; in_addr = v.addr; in_wdata = v.wdata; dresp_data_ok = 1'b0;
        sbq.push_back('{rdata: v.rdata, mis: 1'b0});
        #1;
        chk1("idle_dwait", Dwait, 1'b1);
        chk1("idle_dreq_valid", dreq_valid, 1'b0);
        for (int unsigned k = 0; k < v.lat; k++) begin
            @(negedge clk);
            if (flush) in_valid = 1'b0;
            dresp_data_ok = (k == v.lat - 1);
            dresp_data = (k == v.lat - 1) ? v.resp : {$urandom, $urandom};
            #1;
            chk1("req_valid", dreq_valid, 1'b1);
            chk1("req_dwait", Dwait, 1'b1);
            chk1("req_done", out_done, 1'b0);
            chk64("req_addr", dreq_addr, v.addr);
            chk64("req_size", 64'(dreq_size), 64'({1'b0, v.sz}));
            chk64("req_strobe", 64'(dreq_strobe), 64'(v.strb));
            chk64("req_data", dreq_data, v.bdata);
        end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk1("done_flag", out_done, 1'b1);
        chk1("done_dwait", Dwait, 1'b0);
        chk1("done_dreq_valid", dreq_valid, 1'b0);
        last_rdata = v.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //        ld    st    sz    uns   addr                   wdata                  resp                   lat strb   bdata                  rdata
        vecs[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_1003, 64'h0,                 64'h1122_3344_8000_0000, 1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_1002, 64'h0000_0000_0000_ABCD, 64'h0,                 3, 8'h0C, 64'h0000_0000_ABCD_0000, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_2004, 64'h0,                 64'hDEAD_BEEF_1234_5678, 1, 8'h00, 64'h0,                 64'h0000_0000_DEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_2008, 64'h0,                 64'h0123_4567_89AB_CDEF, 1, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h0000_0000_0000_0006, 64'h0,                 64'h8001_0000_0000_0000, 2, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h0000_0000_0000_0006, 64'h0,                 64'h8001_0000_0000_0000, 1, 8'h00, 64'h0,                 64'h0000_0000_0000_8001};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h0000_0000_0000_0004, 64'h0,                 64'h8000_0000_0000_0000, 1, 8'h00, 64'h0,                 64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h0000_0000_0000_0010, 64'h0102_0304_0506_0708, 64'h0,                 2, 8'hFF, 64'h0102_0304_0506_0708, 64'h0};
        vecs[8] = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_FFEE, 64'h0,                 1, 8'h80, 64'hEE00_0000_0000_0000, 64'h0};
        vecs[9] = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_0005, 64'h0,                 64'h0000_F000_0000_0000, 1, 8'h00, 64'h0,                 64'h0000_0000_0000_00F0};

        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rst_dreq_valid", dreq_valid, 1'b0);
        chk64("rst_dreq_addr", dreq_addr, 64'h0);
        chk64("rst_dreq_size", 64'(dreq_size), 64'h0);
        chk64("rst_dreq_strobe", 64'(dreq_strobe), 64'h0);
        chk64("rst_dreq_data", dreq_data, 64'h0);
        chk1("rst_done", out_done, 1'b0);
        chk64("rst_rdata", out_rdata, 64'h0);
        chk1("rst_dwait", Dwait, 1'b0);

        // Back-to-back transactions; entries 2 and 3 give the Dwait 1,1,0,1,1,0 pattern.
        for (int i = 0; i < 10; i++) do_op(vecs[i], 1'b0);

        // Non-memory op with stray data_ok: no request, no stall, last load data held.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
            dresp_data_ok = i[0]; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            chk1("alu_dreq_valid", dreq_valid, 1'b0);
            chk1("alu_dwait", Dwait, 1'b0);
            chk1("alu_done", out_done, 1'b0);
            chk64("alu_rdata_hold", out_rdata, last_rdata);
        end
        @(negedge clk);
        drive_idle();
        in_is_load = 1'b1;
        #1;
        chk1("bubble_dwait", Dwait, 1'b0);

        // Pipeline flush during REQ: request is not withdrawn.
        extra = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_4000, 64'h0, 64'h5555_AAAA_5555_AAAA, 2, 8'h00, 64'h0, 64'h5555_AAAA_5555_AAAA};
        do_op(extra, 1'b1);

`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_is_load = (i == 0); in_is_store = (i != 0); in_unsigned = 1'b0;
            in_size = (i == 0) ? 2'd2 : 2'd3;
            in_addr = (i == 0) ? 64'h0000_0000_8000_0002 : 64'h0000_0000_0000_0003;
            in_wdata = 64'h0102_0304_0506_0708; dresp_data_ok = 1'b0;
            sbq.push_back('{rdata: 64'h0, mis: 1'b1});
            #1;
            chk1("mis_idle_dwait", Dwait, 1'b1);
            chk1("mis_idle_valid", dreq_valid, 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk1("mis_done", out_done, 1'b1);
            chk1("mis_flag", out_misalign, 1'b1);
            chk1("mis_dwait", Dwait, 1'b0);
            chk1("mis_valid", dreq_valid, 1'b0);
        end
`else
        extra = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0002, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 8'h00, 64'h0, 64'hFFFF_FFFF_BBBB_CCCC};
        do_op(extra, 1'b0);
        extra = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h0000_0000_8000_0002, 64'h0000_0000_1122_3344, 64'h0, 1, 8'h3C, 64'h0000_1122_3344_0000, 64'h0};
        do_op(extra, 1'b0);
        extra = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h0000_0000_0000_0003, 64'h0102_0304_0506_0708, 64'h0, 1, 8'hF8, 64'h0405_0607_0800_0000, 64'h0};
        do_op(extra, 1'b0);
`endif

        // Reset in the second REQ cycle; the late data_ok must be ignored.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_size = 2'd3;
        in_addr = 64'h0000_0000_8000_3000; dresp_data_ok = 1'b0;
        @(negedge clk);
        #1;
        chk1("rmid_req1_valid", dreq_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("rmid_req2_valid", dreq_valid, 1'b1);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk1("rmid_valid", dreq_valid, 1'b0);
        chk1("rmid_dwait", Dwait, 1'b0);
        chk1("rmid_done", out_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dresp_data_ok = 1'b0;
            #1;
            chk1("rmid_after_done", out_done, 1'b0);
            chk1("rmid_after_valid", dreq_valid, 1'b0);
            chk64("rmid_after_rdata", out_rdata, 64'h0);
        end

        @(negedge clk);
        drive_idle();
        #3;
        chk64("sb_drain", 64'(sbq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
